operand_issue_queue: RTL and testbench

- Upstream stage of the operand-select/sign-pipe test block; buffers incoming operand pairs (opa, opb) plus the fast-path select and presents them one at a time.
- Valid/ready handshake on both sides; synchronous flush; wrapping issue counter.
- Outputs opa, opb and fast drive the consumer's like-named inputs directly; opa/opb stay the taint sources of the downstream stage.

---
 rtl/operand_issue_queue.sv | 109 ++++++++++
 tb/tb_operand_issue_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_queue.sv
// Operand-pair issue queue: buffers (opa, opb, fast) and presents the head with valid/ready.
// Optional build macro ISSUE_ZERO_IDLE_EN forces opa/opb/fast to zero while the queue is empty.
module operand_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_opa,
  input  logic [WIDTH-1:0]         in_opb,
  input  logic                     in_fast,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         opa,
  output logic [WIDTH-1:0]         opb,
  output logic                     fast,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         issued_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem_opa  [DEPTH];
  logic [WIDTH-1:0] r_mem_opb  [DEPTH];
  logic             r_mem_fast [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_issued;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign in_ready   = rst_n & ~w_full;
  assign out_valid  = ~w_empty;
  // Flush drops any handshake happening in the same cycle.
  assign w_push     = in_valid & in_ready & ~flush;
  assign w_pop      = out_valid & out_ready & ~flush;
  assign count      = r_count;
  assign issued_cnt = r_issued;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_issued <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_issued <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_issued <= r_issued + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_opa[r_wr_ptr]  <= in_opa;
      r_mem_opb[r_wr_ptr]  <= in_opb;
      r_mem_fast[r_wr_ptr] <= in_fast;
    end
  end

`ifdef ISSUE_ZERO_IDLE_EN
  assign opa  = out_valid ? r_mem_opa[r_rd_ptr]  : '0;
  assign opb  = out_valid ? r_mem_opb[r_rd_ptr]  : '0;
  assign fast = out_valid ? r_mem_fast[r_rd_ptr] : 1'b0;
`else
  // Last issued pair is held so an idle queue keeps showing stale operands; reset clears it.
  logic [WIDTH-1:0] r_last_opa;
  logic [WIDTH-1:0] r_last_opb;
  logic             r_last_fast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_opa  <= '0;
      r_last_opb  <= '0;
      r_last_fast <= 1'b0;
    end else if (w_pop) begin
      r_last_opa  <= r_mem_opa[r_rd_ptr];
      r_last_opb  <= r_mem_opb[r_rd_ptr];
      r_last_fast <= r_mem_fast[r_rd_ptr];
    end
  end

  assign opa  = out_valid ? r_mem_opa[r_rd_ptr]  : r_last_opa;
  assign opb  = out_valid ? r_mem_opb[r_rd_ptr]  : r_last_opb;
  assign fast = out_valid ? r_mem_fast[r_rd_ptr] : r_last_fast;
`endif

endmodule

// File: tb/tb_operand_issue_queue.sv
// Scoreboard bench for operand_issue_queue: a queue model predicts handshake, head data and counters.
module tb_operand_issue_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_opa = '0;
  logic [WIDTH-1:0] in_opb = '0;
  logic             in_fast = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             fast;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] issued_cnt;

  always #5 clk = ~clk;

  operand_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_fast(in_fast), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .opa(opa), .opb(opb),
    .fast(fast), .count(count), .issued_cnt(issued_cnt)
  );

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             f;
  } pair_t;

  pair_t            sb_q[$];
  pair_t            m_last = '0;
  logic [CNT_W-1:0] m_issued = '0;
  int               n_vec = 0;
  int               n_err = 0;
  bit               mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the presented head against the model, then predict what the next edge does.
  always @(negedge clk) begin
    pair_t hd;
    int    sz;
    bit    do_pop;
    bit    do_push;
    if (rst_n && mon_en) begin
      sz = sb_q.size();
      check_val("count", 64'(count), 64'(sz));
      check_val("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      check_val("out_valid", 64'(out_valid), 64'(sz != 0));
      check_val("issued_cnt", 64'(issued_cnt), 64'(m_issued));
      if (sz != 0) hd = sb_q[0];
`ifdef ISSUE_ZERO_IDLE_EN
      else hd = '0;
`else
      else hd = m_last;
`endif
      check_val("opa", 64'(opa), 64'(hd.a));
      check_val("opb", 64'(opb), 64'(hd.b));
      check_val("fast", 64'(fast), 64'(hd.f));
      if (flush) begin
        sb_q.delete();
        m_issued = '0;
      end else begin
        do_pop  = (sz != 0) && out_ready;
        do_push = in_valid && (sz < DEPTH);
        if (do_pop) begin
          m_last = sb_q.pop_front();
          m_issued = m_issued + 1'b1;
        end
        if (do_push) sb_q.push_back({in_opa, in_opb, in_fast});
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic f, input logic r, input logic fl);
    in_valid  = v;
    in_opa    = a;
    in_opb    = b;
    in_fast   = f;
    out_ready = r;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_idle;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'(0));
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_count", 64'(count), 64'(0));
    check_val("rst_issued", 64'(issued_cnt), 64'(0));
    check_val("rst_opa", 64'(opa), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // single pair, visible the cycle after the push edge
    drive(1'b1, 32'h8000_0001, 32'h4000_0002, 1'b1, 1'b0, 1'b0);
    check_val("first_valid", 64'(out_valid), 64'(1));
    check_val("first_opa", 64'(opa), 64'h8000_0001);
    check_val("first_opb", 64'(opb), 64'h4000_0002);
    check_val("first_fast", 64'(fast), 64'(1));
    check_val("first_count", 64'(count), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // fill to full, fifth offer ignored, then drain in order
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'(i & 1), 1'b0, 1'b0);
    check_val("full_count", 64'(count), 64'(4));
    check_val("full_in_ready", 64'(in_ready), 64'(0));
    drive(1'b1, 32'hA000_0004, 32'hB000_0004, 1'b1, 1'b0, 1'b0);
    check_val("fifth_ignored_count", 64'(count), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check_val("drain_order_opa", 64'(opa), 64'(32'hA000_0000 + 32'(i)));
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    end
    check_val("drain_issued", 64'(issued_cnt), 64'(4));
    check_val("drain_out_valid", 64'(out_valid), 64'(0));

    // full with simultaneous push offer and pop
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC000_0010, 32'hD000_0010, 1'b1, 1'b1, 1'b0);
    check_val("full_pushpop_count", 64'(count), 64'(3));
    drive(1'b1, 32'hC000_0011, 32'hD000_0011, 1'b1, 1'b0, 1'b0);
    check_val("refill_count", 64'(count), 64'(4));

    // flush with concurrent push and pop
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check_val("pre_flush_count", 64'(count), 64'(2));
    drive(1'b1, 32'hEEEE_0000, 32'hEEEE_0001, 1'b1, 1'b1, 1'b1);
    check_val("flush_count", 64'(count), 64'(0));
    check_val("flush_out_valid", 64'(out_valid), 64'(0));
    check_val("flush_issued", 64'(issued_cnt), 64'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_val("flush_no_push", 64'(count), 64'(0));

    // issued_cnt wrap: one pair in flight, then streaming push+pop
    drive(1'b1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++)
      drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, 1'b0);
    check_val("issued_ffff", 64'(issued_cnt), 64'hFFFF);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check_val("issued_wrap", 64'(issued_cnt), 64'h0);
    check_val("wrap_empty", 64'(out_valid), 64'(0));

    // idle output after draining 0xDEADBEEF
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
`ifdef ISSUE_ZERO_IDLE_EN
    exp_idle = '0;
`else
    exp_idle = 32'hDEAD_BEEF;
`endif
    check_val("idle_opa", 64'(opa), 64'(exp_idle));

    // random traffic, then reset mid-cycle with entries queued
    for (int i = 0; i < 40; i++)
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
    drive(1'b1, 32'h5555_0000, 32'h6666_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5555_0001, 32'h6666_0001, 1'b1, 1'b0, 1'b0);
    check_val("pre_reset_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb_q.delete();
    m_issued = '0;
    m_last = '0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    check_val("midrst_count", 64'(count), 64'(0));
    check_val("midrst_in_ready", 64'(in_ready), 64'(0));
    check_val("midrst_issued", 64'(issued_cnt), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++)
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
